// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register file widths and writeback arbiter state encoding
package rf_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  // One-hot over two bits so a corrupted state register has somewhere to recover from
  typedef enum logic [1:0] {
    S_INIT = 2'b01,
    S_RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/rf_wb_prio.sv
// rtl/rf_wb_prio.sv - LSU-first writeback grant with a saturating ALU aging counter
module rf_wb_prio #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_ready,
  output logic lsu_ready
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          starved;

  assign starved = alu_valid && (wait_cnt == CW'(MAX_WAIT));

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (run) begin
      if (starved) begin
        alu_ready = 1'b1;
      end else begin
        lsu_ready = 1'b1;
        alu_ready = !lsu_valid;
      end
    end
  end

  // Ages only while the ALU is actually waiting; any ALU win or idle cycle restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!run || !alu_valid || alu_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - zero-sweeps reg_file after reset, then arbitrates ALU/LSU writebacks
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int AW       = rf_pkg::AW,
  parameter int NREGS    = rf_pkg::NREGS,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd_addr,
  input  logic [XLEN-1:0] alu_rd_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd_addr,
  input  logic [XLEN-1:0] lsu_rd_data,
  output logic            reg_write,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            init_done
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic            wr_en_d;
  logic [AW-1:0]   addr_d;
  logic [XLEN-1:0] data_d;
  logic            done_d;
  logic            run;
  logic            alu_acc;
  logic            lsu_acc;

  assign run     = (state_q == S_RUN);
  assign alu_acc = alu_valid && alu_ready;
  assign lsu_acc = lsu_valid && lsu_ready;

  rf_wb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .alu_ready (alu_ready),
    .lsu_ready (lsu_ready)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wr_en_d = 1'b0;
    addr_d  = rd_addr;
    data_d  = rd_data;
    done_d  = init_done;
    case (state_q)
      S_INIT: begin
        wr_en_d = 1'b1;
        addr_d  = sweep_q;
        data_d  = '0;
        done_d  = 1'b0;
        // Stop on the last register rather than incrementing, so the counter never wraps
        if (sweep_q == LAST_REG) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      S_RUN: begin
        // x0 is hardwired: the handshake completes but nothing reaches reg_file
        if (lsu_acc) begin
          if (lsu_rd_addr != '0) begin
            wr_en_d = 1'b1;
            addr_d  = lsu_rd_addr;
            data_d  = lsu_rd_data;
          end
        end else if (alu_acc) begin
          if (alu_rd_addr != '0) begin
            wr_en_d = 1'b1;
            addr_d  = alu_rd_addr;
            data_d  = alu_rd_data;
          end
        end
      end
      default: begin
        state_d = S_INIT;
        sweep_d = AW'(1);
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      sweep_q   <= AW'(1);
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      reg_write <= wr_en_d;
      rd_addr   <= addr_d;
      rd_data   <= data_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a behavioural reg_file
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd_addr;
  logic [XLEN-1:0] alu_rd_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd_addr;
  logic [XLEN-1:0] lsu_rd_data;
  logic            reg_write;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            init_done;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]   q_addr[$];
  logic [XLEN-1:0] q_data[$];
  logic [XLEN-1:0] rf[0:NREGS-1];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd_addr (alu_rd_addr),
    .alu_rd_data (alu_rd_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd_addr (lsu_rd_addr),
    .lsu_rd_data (lsu_rd_data),
    .reg_write   (reg_write),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .init_done   (init_done)
  );

  // reg_file: no reset, x0 reads as zero
  always @(posedge clk) begin
    if (reg_write && rd_addr != '0) rf[rd_addr] <= rd_data;
  end

  function automatic logic [XLEN-1:0] rf_read(input int a);
    if (a == 0) return '0;
    return rf[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [XLEN-1:0] d);
    q_addr.push_back(AW'(a));
    q_data.push_back(d);
  endtask

  task automatic push_sweep(input int last);
    for (int r = 1; r <= last; r++) push(r, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Monitor: every registered write pulse must match the next expected write
  initial begin
    logic [AW-1:0]   ea;
    logic [XLEN-1:0] ed;
    forever begin
      @(negedge clk);
      if (reg_write === 1'b1) begin
        if (q_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", rd_addr, rd_data);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          check("wb_addr", 64'(rd_addr), 64'(ea));
          check("wb_data", 64'(rd_data), 64'(ed));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int idx;
    bit alu_won;

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd_addr = '0; alu_rd_data = '0;
    lsu_valid = 1'b0; lsu_rd_addr = '0; lsu_rd_data = '0;

    // Reset state
    #12;
    check("rst_reg_write", 64'(reg_write), 64'(0));
    check("rst_rd_addr",   64'(rd_addr),   64'(0));
    check("rst_rd_data",   64'(rd_data),   64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(0));

    // 1. Sweep x1..x31
    push_sweep(31);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("sweep_cycles", 64'(cnt), 64'(31));
    check("sweep_last_addr", 64'(rd_addr), 64'(31));
    check("sweep_last_we", 64'(reg_write), 64'(1));
    @(posedge clk); #1;
    check("post_sweep_we", 64'(reg_write), 64'(0));
    check("post_sweep_done", 64'(init_done), 64'(1));
    check("x31_after_sweep", 64'(rf_read(31)), 64'(0));

    // 2. ALU only
    @(negedge clk);
    alu_valid = 1'b1; alu_rd_addr = 5'd10; alu_rd_data = 32'd5;
    #1;
    check("t2_alu_ready", 64'(alu_ready), 64'(1));
    push(10, 32'd5);
    @(posedge clk); #1;
    check("t2_latency_we", 64'(reg_write), 64'(1));
    @(negedge clk);
    alu_valid = 1'b0;
    @(posedge clk); #1;
    check("t2_x10", 64'(rf_read(10)), 64'(5));

    // 3. Both valid: LSU first, ALU next cycle
    @(negedge clk);
    lsu_valid = 1'b1; lsu_rd_addr = 5'd3; lsu_rd_data = 32'hA;
    alu_valid = 1'b1; alu_rd_addr = 5'd4; alu_rd_data = 32'hB;
    #1;
    check("t3_lsu_ready", 64'(lsu_ready), 64'(1));
    check("t3_alu_blocked", 64'(alu_ready), 64'(0));
    push(3, 32'hA);
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    check("t3_alu_ready", 64'(alu_ready), 64'(1));
    check("t3_we_lsu", 64'(reg_write), 64'(1));
    push(4, 32'hB);
    @(negedge clk);
    alu_valid = 1'b0;
    check("t3_we_alu", 64'(reg_write), 64'(1));
    @(posedge clk); #1;
    check("t3_x3", 64'(rf_read(3)), 64'(32'hA));
    check("t3_x4", 64'(rf_read(4)), 64'(32'hB));

    // 4. ALU starvation: ALU wins on the 5th cycle of contention
    idx = 0;
    alu_won = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        alu_valid = 1'b1; alu_rd_addr = 5'd25; alu_rd_data = 32'h77;
      end
      if (alu_won) alu_valid = 1'b0;
      lsu_valid = 1'b1;
      lsu_rd_addr = AW'(16 + idx);
      lsu_rd_data = 32'h100 + XLEN'(idx);
      #1;
      if (k == 4) begin
        check("t4_alu_turn_alu", 64'(alu_ready), 64'(1));
        check("t4_alu_turn_lsu", 64'(lsu_ready), 64'(0));
        push(25, 32'h77);
        alu_won = 1'b1;
      end else begin
        check("t4_lsu_turn_lsu", 64'(lsu_ready), 64'(1));
        check("t4_lsu_turn_alu", 64'(alu_ready), 64'(0));
        push(16 + idx, 32'h100 + XLEN'(idx));
        idx++;
      end
    end
    @(negedge clk);
    lsu_valid = 1'b0;
    idle(3);
    check("t4_x25", 64'(rf_read(25)), 64'(32'h77));
    check("t4_x16", 64'(rf_read(16)), 64'(32'h100));
    check("t4_x20", 64'(rf_read(20)), 64'(32'h104));
    check("t4_x21", 64'(rf_read(21)), 64'(32'h105));

    // 5. x0 filter
    @(negedge clk);
    alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 32'hDEAD;
    #1;
    check("t5_alu_ready", 64'(alu_ready), 64'(1));
    @(posedge clk); #1;
    check("t5_no_write", 64'(reg_write), 64'(0));
    @(negedge clk);
    alu_valid = 1'b0;
    idle(2);

    // 6. Reset mid-sweep at x12, then full restart with requesters held off
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_sweep(12);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!(reg_write === 1'b1 && rd_addr == 5'd12) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_reached_x12", 64'(cnt < 40), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", 64'(reg_write), 64'(0));
    check("t6_rst_addr", 64'(rd_addr), 64'(0));
    check("t6_rst_data", 64'(rd_data), 64'(0));
    check("t6_rst_done", 64'(init_done), 64'(0));
    check("t6_rst_lsu_ready", 64'(lsu_ready), 64'(0));
    push_sweep(31);
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 32'hBAD;
    lsu_valid = 1'b1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'hBAD;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      #1;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0)
        check("t6_ready_held", 64'({alu_ready, lsu_ready}), 64'(0));
      @(negedge clk);
      cnt++;
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    check("t6_restart_cycles", 64'(cnt), 64'(31));
    idle(3);
    check("t6_x10_cleared", 64'(rf_read(10)), 64'(0));
    check("t6_x25_cleared", 64'(rf_read(25)), 64'(0));
    check("scoreboard_drained", 64'(q_addr.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
